// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the KGP instruction fetch front end.
package kgp_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] PC_INCR = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo_mem.sv
// Register-array storage for the prefetch queue: one write port, one combinational read port.
module fetch_fifo_mem
  import kgp_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [PTR_W-1:0]   waddr_i,
  input  fetch_entry_t       wdata_i,
  input  logic [PTR_W-1:0]   raddr_i,
  output fetch_entry_t       rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: issues ROM reads against a credit limit and queues {instr, pc} for decode.
module instr_prefetch_queue
  import kgp_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rom_req,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_addr,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic             rsp_pending_q, rsp_pending_d;
  logic [PC_W-1:0]  rsp_pc_q, rsp_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight;
  logic             push, pop;
  fetch_entry_t     wr_entry, head;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^redirect_addr[1:0];

  // Queued entries plus the outstanding response must fit, so a response always has a slot.
  assign inflight  = count_q + CNT_W'(rsp_pending_q);
  assign rom_req   = rst & ~redirect & (inflight < CNT_W'(DEPTH));
  assign rom_addr  = fetch_pc_q;

  assign push      = rsp_pending_q & ~redirect;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready & ~redirect;

  assign wr_entry.instr = rom_data;
  assign wr_entry.pc    = rsp_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pending_d = rsp_pending_q;
    rsp_pc_d      = rsp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect) begin
      fetch_pc_d    = {redirect_addr[PC_W-1:2], 2'b00};
      rsp_pending_d = 1'b0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
    end else begin
      if (rom_req) begin
        rsp_pending_d = 1'b1;
        rsp_pc_d      = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_INCR;
      end else begin
        rsp_pending_d = 1'b0;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pending_q <= 1'b0;
      rsp_pc_q      <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_pc_q      <= rsp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  fetch_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: two instances (RESET_PC 0 and FFFF_FFF8) with XOR-pattern ROMs.
module tb_instr_prefetch_queue;

  localparam logic [31:0] XK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, redirect_a, out_ready_a, rom_req_a, out_valid_a;
  logic [31:0] redirect_addr_a, rom_addr_a, out_instr_a, out_pc_a;
  logic [31:0] rom_data_a = '0;

  logic        rst_b, redirect_b, out_ready_b, rom_req_b, out_valid_b;
  logic [31:0] redirect_addr_b, rom_addr_b, out_instr_b, out_pc_b;
  logic [31:0] rom_data_b = '0;

  int n_checks = 0;
  int n_errors = 0;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst_a), .rom_req(rom_req_a), .rom_addr(rom_addr_a),
    .rom_data(rom_data_a), .redirect(redirect_a), .redirect_addr(redirect_addr_a),
    .out_valid(out_valid_a), .out_instr(out_instr_a), .out_pc(out_pc_a),
    .out_ready(out_ready_a)
  );

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst_b), .rom_req(rom_req_b), .rom_addr(rom_addr_b),
    .rom_data(rom_data_b), .redirect(redirect_b), .redirect_addr(redirect_addr_b),
    .out_valid(out_valid_b), .out_instr(out_instr_b), .out_pc(out_pc_b),
    .out_ready(out_ready_b)
  );

  // Synchronous ROMs with one cycle of read latency.
  always @(posedge clk) if (rom_req_a) rom_data_a <= rom_addr_a ^ XK;
  always @(posedge clk) if (rom_req_b) rom_data_b <= rom_addr_b ^ XK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_o(input string tag,
                          input logic req_g, input logic [31:0] addr_g,
                          input logic vld_g, input logic [31:0] pc_g, input logic [31:0] instr_g,
                          input logic req, input logic [31:0] addr,
                          input logic vld, input logic [31:0] pc);
    check({tag, "_req"}, 32'(req_g), 32'(req));
    if (req) check({tag, "_addr"}, addr_g, addr);
    check({tag, "_vld"}, 32'(vld_g), 32'(vld));
    if (vld) begin
      check({tag, "_pc"}, pc_g, pc);
      check({tag, "_instr"}, instr_g, pc ^ XK);
    end
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    start_cycle();
    rst_a = 1'b0;
    start_cycle();
    rst_a = 1'b1;
  endtask

  task automatic exp_a(input string tag, input logic req, input logic [31:0] addr,
                       input logic vld, input logic [31:0] pc);
    @(negedge clk);
    expect_o(tag, rom_req_a, rom_addr_a, out_valid_a, out_pc_a, out_instr_a, req, addr, vld, pc);
  endtask

  logic [31:0] seq_b [6];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    seq_b = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000,
              32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
    rst_a = 1'b0; redirect_a = 1'b0; out_ready_a = 1'b0; redirect_addr_a = '0;
    rst_b = 1'b0; redirect_b = 1'b0; out_ready_b = 1'b0; redirect_addr_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",   32'(rom_req_a),   32'd0);
    check("rst_vld",   32'(out_valid_a), 32'd0);
    check("rst_instr", out_instr_a,      32'd0);
    check("rst_pc",    out_pc_a,         32'd0);
    check("rst_req_b", 32'(rom_req_b),   32'd0);

    // Streaming with decode always ready
    start_cycle();
    rst_a = 1'b1; out_ready_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) start_cycle();
      exp_a("stream", 1'b1, 32'(4 * k), k >= 2, 32'(4 * (k - 2)));
    end

    // Backpressure: fill to DEPTH, then release one credit
    out_ready_a = 1'b0;
    reset_a();
    for (int k = 0; k < 8; k++) begin
      if (k != 0) start_cycle();
      exp_a("fill", k < 4, 32'(4 * k), k >= 2, 32'd0);
    end
    check("fill_count", 32'(dut_a.count_q), 32'd4);
    start_cycle(); out_ready_a = 1'b1;
    exp_a("pop1", 1'b0, 32'd0, 1'b1, 32'd0);
    start_cycle(); out_ready_a = 1'b0;
    exp_a("credit", 1'b1, 32'd16, 1'b1, 32'd4);
    start_cycle();
    exp_a("credit_n1", 1'b0, 32'd0, 1'b1, 32'd4);
    start_cycle();
    exp_a("credit_n2", 1'b0, 32'd0, 1'b1, 32'd4);
    check("credit_count", 32'(dut_a.count_q), 32'd4);

    // Reset mid-stream with 3 entries queued and one response pending
    reset_a();
    for (int k = 1; k < 4; k++) start_cycle();
    start_cycle();
    check("mid_count", 32'(dut_a.count_q), 32'd3);
    check("mid_pend",  32'(dut_a.rsp_pending_q), 32'd1);
    rst_a = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_valid_a), 32'd0);
    check("mid_rst_req", 32'(rom_req_a),   32'd0);
    check("mid_rst_pc",  out_pc_a,         32'd0);
    start_cycle();
    rst_a = 1'b1; out_ready_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) start_cycle();
      exp_a("restart", 1'b1, 32'(4 * k), k >= 2, 32'(4 * (k - 2)));
    end

    // Redirect in cycle 5 drops the in-flight response
    reset_a();
    for (int k = 0; k < 5; k++) begin
      if (k != 0) start_cycle();
      exp_a("pre_rd", 1'b1, 32'(4 * k), k >= 2, 32'(4 * (k - 2)));
    end
    start_cycle(); redirect_a = 1'b1; redirect_addr_a = 32'h0000_0103;
    exp_a("rd_c5", 1'b0, 32'd0, 1'b1, 32'd12);
    start_cycle(); redirect_a = 1'b0;
    exp_a("rd_c6", 1'b1, 32'h100, 1'b0, 32'd0);
    start_cycle();
    exp_a("rd_c7", 1'b1, 32'h104, 1'b0, 32'd0);
    start_cycle();
    exp_a("rd_c8", 1'b1, 32'h108, 1'b1, 32'h100);
    start_cycle();
    exp_a("rd_c9", 1'b1, 32'h10C, 1'b1, 32'h104);

    // Redirect with full queue and out_ready high, then a back-to-back redirect
    out_ready_a = 1'b0;
    reset_a();
    for (int k = 1; k < 6; k++) start_cycle();
    check("full_count", 32'(dut_a.count_q), 32'd4);
    start_cycle(); redirect_a = 1'b1; out_ready_a = 1'b1; redirect_addr_a = 32'h0000_0200;
    exp_a("full_rd", 1'b0, 32'd0, 1'b1, 32'd0);
    start_cycle(); redirect_addr_a = 32'h0000_0303;
    #1;
    check("full_rd_count", 32'(dut_a.count_q), 32'd0);
    exp_a("b2b_rd", 1'b0, 32'd0, 1'b0, 32'd0);
    start_cycle(); redirect_a = 1'b0;
    exp_a("b2b_c1", 1'b1, 32'h300, 1'b0, 32'd0);
    start_cycle();
    exp_a("b2b_c2", 1'b1, 32'h304, 1'b0, 32'd0);
    start_cycle();
    exp_a("b2b_c3", 1'b1, 32'h308, 1'b1, 32'h300);

    // Address wrap from RESET_PC = FFFF_FFF8
    start_cycle(); rst_b = 1'b1; out_ready_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) start_cycle();
      @(negedge clk);
      expect_o("wrap", rom_req_b, rom_addr_b, out_valid_b, out_pc_b, out_instr_b,
               1'b1, seq_b[k], k >= 2, (k >= 2) ? seq_b[k - 2] : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
